traffic_lamp_monitor: RTL and testbench
=======================================

TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameter MIN_GREEN, 4, minimum consecutive green cycles per phase.
REQ-002 Parameter MIN_YELLOW, 2, minimum consecutive yellow cycles per phase.
REQ-003 Parameter MAX_YELLOW, 6, maximum consecutive yellow cycles per phase.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 lamp_in  input  12  lamp states: [2:0] north, [5:3] east, [8:6] south, [11:9] west; each {red,yellow,green}, bit2=red, bit0=green.
REQ-007 fault_clr  input  1  single-cycle clear of the latched fault.
REQ-008 phase  output  2  0 ALL_RED, 1 GREEN, 2 YELLOW, 3 RESYNC.
REQ-009 active_dir  output  2  0 N, 1 E, 2 S, 3 W; valid when active_valid=1.
REQ-010 active_valid  output  1  1 in GREEN or YELLOW.
REQ-011 fault  output  1  sticky fault flag.
REQ-012 fault_code  output  3  code of the first latched fault; 0 = none.
REQ-013 phase_count  output  16  count of completed legal green-yellow-red phases, wraps at 16'hFFFF->0.

Function
REQ-014 lamp_in SHALL be sampled every rising edge; all outputs are registered and reflect the sample of the same edge (no extra latency).
REQ-015 Per direction, a legal lamp is exactly one bit set; any other pattern SHALL raise code 1 (LAMP_ILLEGAL).
REQ-016 More than one direction non-red in one sample SHALL raise code 2 (CONFLICT).
REQ-017 FSM: ALL_RED->GREEN(d) when only d is green; GREEN(d)->YELLOW(d); YELLOW(d)->ALL_RED; staying in a state is legal.
REQ-018 Any other transition (ALL_RED->YELLOW, GREEN->ALL_RED, YELLOW->GREEN, direction change without ALL_RED) SHALL raise code 3 (BAD_SEQUENCE).
REQ-019 GREEN->YELLOW with green duration < MIN_GREEN SHALL raise code 6 (GREEN_SHORT).
REQ-020 YELLOW->ALL_RED with yellow duration < MIN_YELLOW SHALL raise code 4 (YELLOW_SHORT).
REQ-021 Yellow duration reaching MAX_YELLOW+1 SHALL raise code 5 (YELLOW_LONG) on that edge.
REQ-022 Durations count sampled cycles including the entry cycle; 8-bit counter, saturating at 255.
REQ-023 Legal YELLOW->ALL_RED SHALL increment phase_count by 1.
REQ-024 Simultaneous faults: lowest code number wins.
REQ-025 On any fault the FSM SHALL enter RESYNC and return to ALL_RED on the first all-red sample; no fault detection while in RESYNC except code 1.
REQ-026 fault/fault_code latch the first fault only; later faults do not overwrite while fault=1.
REQ-027 fault_clr clears fault and fault_code next edge; fault_clr with a new fault on the same edge: new fault latched.

Reset
REQ-028 reset SHALL force phase=ALL_RED, active_dir=0, active_valid=0, fault=0, fault_code=0, phase_count=0, duration counter=0, immediately and regardless of clk, including mid-phase.

Configuration
REQ-029 Macro TRAFFIC_MON_TIMING_EN defined: duration counter and codes 4, 5, 6 present.
REQ-030 Macro undefined: no duration counter, codes 4/5/6 never produced, MIN_/MAX_ parameters ignored; all other behaviour identical.

Structure
REQ-031 Package traffic_pkg SHALL hold phase encodings, direction encodings, fault code constants, and lamp bit-index constants.
REQ-032 Sub-module traffic_dir_decode (combinational) SHALL decode one 3-bit lamp group into {is_red, is_yellow, is_green, illegal}; instantiated four times.

Verification
REQ-033 Reset; all red 3 cycles, N green 4, N yellow 2, all red -> phases 0,1,2,0, active_dir=0, phase_count=1, fault=0.
REQ-034 lamp_in=12'b100_100_001_001 (N and E green) -> fault=1, fault_code=2, phase=RESYNC.
REQ-035 North group 3'b011 -> fault_code=1; later conflicting sample does not change fault_code.
REQ-036 E green 4 cycles then all red -> fault_code=3; fault_clr with all red -> fault=0, fault_code=0, phase=ALL_RED.
REQ-037 S green 4, S yellow 1, all red: with TRAFFIC_MON_TIMING_EN -> fault_code=4; without -> fault=0, phase_count=1; S yellow 7 cycles with macro -> fault_code=5 on 7th.
REQ-038 Assert reset mid-YELLOW with phase_count=5 -> all outputs zero before next clk edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared encodings for the traffic lamp monitor: phase and direction codes,
// fault codes, lamp bit positions inside one 3-bit direction group, and a
// saturating increment for the duration counter.
// No ports (package).
// -----------------------------------------------------------------------------
package traffic_pkg;

  // Reported phase (value of the phase output)
  localparam logic [1:0] PH_ALL_RED = 2'd0;
  localparam logic [1:0] PH_GREEN   = 2'd1;
  localparam logic [1:0] PH_YELLOW  = 2'd2;
  localparam logic [1:0] PH_RESYNC  = 2'd3;

  // Direction encoding; also the group index inside lamp_in
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Fault codes; a lower number has higher priority
  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_LAMP_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_BAD_SEQUENCE = 3'd3;
  localparam logic [2:0] FC_YELLOW_SHORT = 3'd4;
  localparam logic [2:0] FC_YELLOW_LONG  = 3'd5;
  localparam logic [2:0] FC_GREEN_SHORT  = 3'd6;

  // Lamp bit positions within one direction group
  localparam int LAMP_GROUP_W   = 3;
  localparam int LAMP_GREEN_BIT = 0;
  localparam int LAMP_YELLOW_BIT = 1;
  localparam int LAMP_RED_BIT   = 2;
  localparam int NUM_DIRS       = 4;

  localparam logic [2:0] LAMP_GREEN  = 3'(1 << LAMP_GREEN_BIT);
  localparam logic [2:0] LAMP_YELLOW = 3'(1 << LAMP_YELLOW_BIT);
  localparam logic [2:0] LAMP_RED    = 3'(1 << LAMP_RED_BIT);

  localparam int DUR_W = 8;

  // Duration counter increment that sticks at all-ones
  function automatic logic [DUR_W-1:0] dur_sat_inc(input logic [DUR_W-1:0] v);
    return (&v) ? v : v + DUR_W'(1);
  endfunction

endpackage

// File: rtl/traffic_dir_decode.sv
// -----------------------------------------------------------------------------
// traffic_dir_decode
// Combinational decode of one direction's {red,yellow,green} lamp group.
// A group is legal only when exactly one lamp is lit.
// Ports:
//   lamp      in  [2:0]  lamp group, bit2=red, bit1=yellow, bit0=green
//   is_red    out        only the red lamp is lit
//   is_yellow out        only the yellow lamp is lit
//   is_green  out        only the green lamp is lit
//   illegal   out        zero or more than one lamp lit
// -----------------------------------------------------------------------------
module traffic_dir_decode
  import traffic_pkg::*;
(
  input  logic [2:0] lamp,
  output logic       is_red,
  output logic       is_yellow,
  output logic       is_green,
  output logic       illegal
);

  assign is_red    = (lamp == LAMP_RED);
  assign is_yellow = (lamp == LAMP_YELLOW);
  assign is_green  = (lamp == LAMP_GREEN);
  assign illegal   = !(is_red || is_yellow || is_green);

endmodule

// File: rtl/traffic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// traffic_lamp_monitor
// Watches the four lamp groups of an intersection every clock, tracks the
// green -> yellow -> all-red phase sequence and latches the first fault seen.
// After a fault it sits in RESYNC until an all-red sample is observed.
//
// Optional feature (macro TRAFFIC_MON_TIMING_EN): duration counter with
// GREEN_SHORT, YELLOW_SHORT and YELLOW_LONG checks. Without the macro the
// MIN_/MAX_ parameters have no effect.
//
// Ports:
//   clk          in        rising-edge clock
//   reset        in        asynchronous active-high reset
//   lamp_in      in  [11:0] {W,S,E,N} lamp groups, each {red,yellow,green}
//   fault_clr    in        clears the latched fault on the next edge
//   phase        out [1:0] ALL_RED / GREEN / YELLOW / RESYNC
//   active_dir   out [1:0] direction owning the phase (0 when not active)
//   active_valid out       phase is GREEN or YELLOW
//   fault        out       sticky fault flag
//   fault_code   out [2:0] code of the first latched fault
//   phase_count  out [15:0] completed legal phases, wrapping
// -----------------------------------------------------------------------------
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_YELLOW = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] lamp_in,
  input  logic        fault_clr,
  output logic [1:0]  phase,
  output logic [1:0]  active_dir,
  output logic        active_valid,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] phase_count
);

  logic [NUM_DIRS-1:0] red, yellow, green, illegal;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dec
    traffic_dir_decode u_dec (
      .lamp      (lamp_in[i*LAMP_GROUP_W +: LAMP_GROUP_W]),
      .is_red    (red[i]),
      .is_yellow (yellow[i]),
      .is_green  (green[i]),
      .illegal   (illegal[i])
    );
  end

  // Sample classification
  logic [NUM_DIRS-1:0] non_red;
  logic                any_illegal, multi_non_red, all_red;
  logic [1:0]          sample_dir;
  logic                sample_green, sample_yellow, same_dir;

  assign non_red       = ~red;
  assign any_illegal   = |illegal;
  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi_non_red = |(non_red & (non_red - 4'd1));
  assign all_red       = (non_red == '0);

  always_comb begin
    sample_dir = DIR_N;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (non_red[i]) sample_dir = 2'(i);
    end
  end

  assign sample_green  = !all_red && green[sample_dir];
  assign sample_yellow = !all_red && yellow[sample_dir];
  assign same_dir      = (sample_dir == active_dir);

`ifdef TRAFFIC_MON_TIMING_EN
  localparam logic [DUR_W-1:0] MIN_GREEN_C  = DUR_W'(MIN_GREEN);
  localparam logic [DUR_W-1:0] MIN_YELLOW_C = DUR_W'(MIN_YELLOW);
  localparam logic [DUR_W-1:0] MAX_YELLOW_C = DUR_W'(MAX_YELLOW);
  logic [DUR_W-1:0] dur_q, dur_nx;
`else
  logic unused_timing_cfg;
  assign unused_timing_cfg = (MIN_GREEN + MIN_YELLOW + MAX_YELLOW) != 0;
`endif

  logic [2:0] det_code;
  logic [1:0] phase_nx, dir_nx;
  logic       count_inc;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    det_code  = FC_NONE;
    phase_nx  = phase;
    dir_nx    = active_dir;
    count_inc = 1'b0;
`ifdef TRAFFIC_MON_TIMING_EN
    dur_nx    = dur_q;
`endif
    if (any_illegal) begin
      det_code = FC_LAMP_ILLEGAL;
    end else if (phase == PH_RESYNC) begin
      // Only the lamp check runs here; wait for an all-red sample
      if (all_red) phase_nx = PH_ALL_RED;
    end else if (multi_non_red) begin
      det_code = FC_CONFLICT;
    end else begin
      case (phase)
        PH_ALL_RED: begin
          if (sample_green) begin
            phase_nx = PH_GREEN;
            dir_nx   = sample_dir;
`ifdef TRAFFIC_MON_TIMING_EN
            dur_nx   = DUR_W'(1);
`endif
          end else if (!all_red) begin
            det_code = FC_BAD_SEQUENCE;
          end
        end
        PH_GREEN: begin
          if (sample_green && same_dir) begin
`ifdef TRAFFIC_MON_TIMING_EN
            dur_nx = dur_sat_inc(dur_q);
`endif
          end else if (sample_yellow && same_dir) begin
            phase_nx = PH_YELLOW;
`ifdef TRAFFIC_MON_TIMING_EN
            if (dur_q < MIN_GREEN_C) det_code = FC_GREEN_SHORT;
            dur_nx = DUR_W'(1);
`endif
          end else begin
            det_code = FC_BAD_SEQUENCE;
          end
        end
        PH_YELLOW: begin
          if (all_red) begin
            phase_nx  = PH_ALL_RED;
            count_inc = 1'b1;
`ifdef TRAFFIC_MON_TIMING_EN
            if (dur_q < MIN_YELLOW_C) det_code = FC_YELLOW_SHORT;
`endif
          end else if (sample_yellow && same_dir) begin
`ifdef TRAFFIC_MON_TIMING_EN
            dur_nx = dur_sat_inc(dur_q);
            if (dur_nx > MAX_YELLOW_C) det_code = FC_YELLOW_LONG;
`endif
          end else begin
            det_code = FC_BAD_SEQUENCE;
          end
        end
        default: ;
      endcase
    end

    if (det_code != FC_NONE) begin
      phase_nx  = PH_RESYNC;
      count_inc = 1'b0;
    end
    if (phase_nx != PH_GREEN && phase_nx != PH_YELLOW) begin
      dir_nx = DIR_N;
`ifdef TRAFFIC_MON_TIMING_EN
      dur_nx = '0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= PH_ALL_RED;
      active_dir  <= DIR_N;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      phase_count <= '0;
    end else begin
      phase      <= phase_nx;
      active_dir <= dir_nx;
      if (count_inc) phase_count <= phase_count + 16'd1;
      // A new fault wins over a clear on the same edge
      if (det_code != FC_NONE && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_code <= det_code;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end
    end
  end

`ifdef TRAFFIC_MON_TIMING_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dur_q <= '0;
    else       dur_q <= dur_nx;
  end
`endif

  assign active_valid = (phase == PH_GREEN) || (phase == PH_YELLOW);

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_lamp_monitor
// Directed table of vectors, hand-written timing/reset sequences, then
// random lamp traffic compared against a rule-level reference model.
// Honours TRAFFIC_MON_TIMING_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_traffic_lamp_monitor;

  localparam int MIN_GREEN  = 4;
  localparam int MIN_YELLOW = 2;
  localparam int MAX_YELLOW = 6;
`ifdef TRAFFIC_MON_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif

  // Lamp words, groups {W,S,E,N}, each {red,yellow,green}
  localparam logic [11:0] AR   = 12'b100_100_100_100;
  localparam logic [11:0] NG   = 12'b100_100_100_001;
  localparam logic [11:0] NY   = 12'b100_100_100_010;
  localparam logic [11:0] NBAD = 12'b100_100_100_011;
  localparam logic [11:0] NE   = 12'b100_100_001_001;
  localparam logic [11:0] EG   = 12'b100_100_001_100;
  localparam logic [11:0] SG   = 12'b100_001_100_100;
  localparam logic [11:0] SY   = 12'b100_010_100_100;
  localparam logic [11:0] WG   = 12'b001_100_100_100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] lamp_in = AR;
  logic        fault_clr = 1'b0;
  logic [1:0]  phase, active_dir;
  logic        active_valid, fault;
  logic [2:0]  fault_code;
  logic [15:0] phase_count;

  traffic_lamp_monitor #(
    .MIN_GREEN  (MIN_GREEN),
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_YELLOW (MAX_YELLOW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lamp_in      (lamp_in),
    .fault_clr    (fault_clr),
    .phase        (phase),
    .active_dir   (active_dir),
    .active_valid (active_valid),
    .fault        (fault),
    .fault_code   (fault_code),
    .phase_count  (phase_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int ph, input int dir, input int valid,
                            input int flt, input int code, input int cnt);
    check({tag, ".phase"},        32'(phase),        32'(ph));
    check({tag, ".active_dir"},   32'(active_dir),   32'(dir));
    check({tag, ".active_valid"}, 32'(active_valid), 32'(valid));
    check({tag, ".fault"},        32'(fault),        32'(flt));
    check({tag, ".fault_code"},   32'(fault_code),   32'(code));
    check({tag, ".phase_count"},  32'(phase_count),  32'(cnt));
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: phase 0 all-red, 1 green, 2 yellow, 3 resync; m_len is the
  // number of samples spent in the current green/yellow phase.
  // ---------------------------------------------------------------------------
  int m_phase, m_dir, m_len, m_fault, m_code, m_count;

  task automatic model_reset();
    m_phase = 0; m_dir = 0; m_len = 0; m_fault = 0; m_code = 0; m_count = 0;
  endtask

  task automatic model_step(input logic [11:0] lamp, input logic clr);
    int  lit[$];
    int  cand[$];
    bit  bad_lamp = 1'b0;
    bit  inc = 1'b0;
    int  nph = m_phase, ndir = m_dir, nlen = m_len;
    int  d, kind, code;
    logic [2:0] g;
    for (int i = 0; i < 4; i++) begin
      g = lamp[3*i +: 3];
      if ($countones(g) != 1) bad_lamp = 1'b1;
      if (g != 3'b100) lit.push_back(i);
    end
    if (bad_lamp) cand.push_back(1);
    if (m_phase != 3 && lit.size() > 1) cand.push_back(2);
    if (m_phase != 3 && !bad_lamp && lit.size() <= 1) begin
      d    = (lit.size() == 0) ? 0 : lit[0];
      kind = (lit.size() == 0) ? 0 : (lamp[3*d] ? 1 : 2);  // 0 red, 1 green, 2 yellow
      case (m_phase)
        0: if (kind == 1) begin nph = 1; ndir = d; nlen = 1; end
           else if (kind == 2) cand.push_back(3);
        1: if (kind == 1 && d == m_dir) nlen = m_len + 1;
           else if (kind == 2 && d == m_dir) begin
             nph = 2; nlen = 1;
             if (TIMING && m_len < MIN_GREEN) cand.push_back(6);
           end else cand.push_back(3);
        default: if (kind == 2 && d == m_dir) begin
             nlen = m_len + 1;
             if (TIMING && nlen > MAX_YELLOW) cand.push_back(5);
           end else if (kind == 0) begin
             nph = 0;
             if (TIMING && m_len < MIN_YELLOW) cand.push_back(4);
             else inc = 1'b1;
           end else cand.push_back(3);
      endcase
    end
    if (m_phase == 3 && lit.size() == 0) nph = 0;
    code = 0;
    if (cand.size() > 0) begin
      code = cand[0];
      foreach (cand[k]) if (cand[k] < code) code = cand[k];
      nph = 3;
      inc = 1'b0;
    end
    if (nph != 1 && nph != 2) begin ndir = 0; nlen = 0; end
    if (code != 0 && (m_fault == 0 || clr)) begin m_fault = 1; m_code = code; end
    else if (clr) begin m_fault = 0; m_code = 0; end
    if (inc) m_count = (m_count + 1) % 65536;
    m_phase = nph; m_dir = ndir; m_len = nlen;
  endtask

  task automatic check_model(input string tag);
    check_outs(tag, m_phase, m_dir, (m_phase == 1 || m_phase == 2) ? 1 : 0,
               m_fault, m_code, m_count);
  endtask

  // Drive one sample, let the edge take it, sample 1 time unit later
  task automatic step(input logic [11:0] lamp, input logic clr);
    lamp_in   = lamp;
    fault_clr = clr;
    model_step(lamp, clr);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge
  task automatic do_reset(input string tag);
    reset     = 1'b1;
    lamp_in   = AR;
    fault_clr = 1'b0;
    #2;
    check_outs(tag, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [11:0] lamp;
    logic        clr;
    int          ph, dir, valid, flt, code, cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [11:0] lamp, input logic clr, input int ph, input int dir,
                     input int valid, input int flt, input int code, input int cnt,
                     input int reps);
    vec_t v;
    v.lamp = lamp; v.clr = clr; v.ph = ph; v.dir = dir; v.valid = valid;
    v.flt = flt; v.code = code; v.cnt = cnt;
    for (int r = 0; r < reps; r++) vecs.push_back(v);
  endtask

  initial begin
    int kind, d, len;
    logic [11:0] lamp;
    logic clr;

    // Power-up reset via the clock edge
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("por", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // lamp, clr, phase, dir, valid, fault, code, count, repeat
    add(AR,   0, 0, 0, 0, 0, 0, 0, 3);  // legal north phase
    add(NG,   0, 1, 0, 1, 0, 0, 0, 4);
    add(NY,   0, 2, 0, 1, 0, 0, 0, 2);
    add(AR,   0, 0, 0, 0, 0, 0, 1, 1);
    add(NE,   0, 3, 0, 0, 1, 2, 1, 1);  // conflict
    add(AR,   0, 0, 0, 0, 1, 2, 1, 1);  // sticky
    add(AR,   1, 0, 0, 0, 0, 0, 1, 1);  // clear
    add(NBAD, 0, 3, 0, 0, 1, 1, 1, 1);  // illegal lamp
    add(NE,   0, 3, 0, 0, 1, 1, 1, 1);  // later conflict keeps code 1
    add(AR,   1, 0, 0, 0, 0, 0, 1, 1);
    add(EG,   0, 1, 1, 1, 0, 0, 1, 4);
    add(AR,   0, 3, 0, 0, 1, 3, 1, 1);  // green -> all red
    add(AR,   1, 0, 0, 0, 0, 0, 1, 1);
    add(NY,   0, 3, 0, 0, 1, 3, 1, 1);  // all red -> yellow
    add(NBAD, 1, 3, 0, 0, 1, 1, 1, 1);  // clear and new fault together
    add(AR,   1, 0, 0, 0, 0, 0, 1, 1);
    add(SG,   0, 1, 2, 1, 0, 0, 1, 4);
    add(WG,   0, 3, 0, 0, 1, 3, 1, 1);  // direction change inside green
    add(AR,   1, 0, 0, 0, 0, 0, 1, 1);
    add(NG,   0, 1, 0, 1, 0, 0, 1, 4);
    add(NY,   0, 2, 0, 1, 0, 0, 1, 2);
    add(NG,   0, 3, 0, 0, 1, 3, 1, 1);  // yellow -> green
    add(AR,   1, 0, 0, 0, 0, 0, 1, 1);

    foreach (vecs[i]) begin
      step(vecs[i].lamp, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].ph, vecs[i].dir, vecs[i].valid,
                 vecs[i].flt, vecs[i].code, vecs[i].cnt);
    end

    // Short yellow: timing build faults, plain build counts a phase
    do_reset("reset_a");
    repeat (4) step(SG, 0);
    step(SY, 0);
    step(AR, 0);
    check_outs("short_yellow", TIMING ? 3 : 0, 0, 0, TIMING ? 1 : 0,
               TIMING ? 4 : 0, TIMING ? 0 : 1);
    step(AR, 1);
    repeat (4) step(SG, 0);
    repeat (6) step(SY, 0);
    check_outs("yellow_6", 2, 2, 1, 0, 0, TIMING ? 0 : 1);
    step(SY, 0);
    check_outs("yellow_7", TIMING ? 3 : 2, TIMING ? 0 : 2, TIMING ? 0 : 1,
               TIMING ? 1 : 0, TIMING ? 5 : 0, TIMING ? 0 : 1);

    // Reset asserted in the middle of a yellow with five phases counted
    do_reset("reset_b");
    for (int p = 0; p < 5; p++) begin
      repeat (4) step(NG, 0);
      repeat (2) step(NY, 0);
      step(AR, 0);
    end
    repeat (4) step(EG, 0);
    step(EG & 12'b111_111_000_111 | 12'b000_000_010_000, 0);
    check_outs("mid_yellow", 2, 1, 1, 0, 0, 5);
    do_reset("reset_mid_yellow");

    // Random traffic against the model
    kind = 0;
    d    = 0;
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 3) != 0) kind = (kind + 1) % 3;
      else kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 6) == 0) d = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 7));
      for (int c = 0; c < len; c++) begin
        lamp = AR;
        if (kind == 1) lamp[3*d +: 3] = 3'b001;
        if (kind == 2) lamp[3*d +: 3] = 3'b010;
        if ($urandom_range(0, 24) == 0) lamp = 12'($urandom);
        clr = ($urandom_range(0, 9) == 0);
        step(lamp, clr);
        check_model($sformatf("rand%0d_%0d", s, c));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
